// File: rtl/overcurrent_retry_ctrl.sv
// Load power-switch sequencer: soft-start with inrush blanking, over-current trip,
// timed cooldown, bounded auto-retry and latched lockout until fault_clr.
module overcurrent_retry_ctrl #(
  parameter int BLANK_CYCLES    = 500,
  parameter int COOLDOWN_CYCLES = 50000,
  parameter int MAX_RETRIES     = 3,
  parameter int STABLE_CYCLES   = 100000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable_req,
  input  logic                             current_high,
  input  logic                             fault_clr,
  output logic                             power_en,
  output logic                             trip_pulse,
  output logic                             fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic [2:0]                       state
);

  localparam int MAX_AB = (BLANK_CYCLES > COOLDOWN_CYCLES) ? BLANK_CYCLES : COOLDOWN_CYCLES;
  localparam int MAX_CD = (MAX_RETRIES > STABLE_CYCLES) ? MAX_RETRIES : STABLE_CYCLES;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW     = $clog2(MAXP + 1);
  localparam int RW     = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] BLANK_LAST  = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] COOL_LAST   = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SOFTSTART = 3'd1,
    ST_RUN       = 3'd2,
    ST_TRIP      = 3'd3,
    ST_LOCKOUT   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            power_en_q, power_en_d;
  logic            trip_pulse_q, trip_pulse_d;
  logic            fault_q, fault_d;
  logic            hold_timer;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    trip_pulse_d = 1'b0;
    hold_timer   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_req) state_d = ST_SOFTSTART;
      end
      ST_SOFTSTART: begin
        if (!enable_req)              state_d = ST_IDLE;
        else if (timer_q == BLANK_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Trip outranks both the disable and the stability clear.
        if (current_high) begin
          state_d      = ST_TRIP;
          trip_pulse_d = 1'b1;
          if (retry_q < RETRY_MAX) retry_d = retry_q + RW'(1);
        end else if (!enable_req) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          retry_d    = '0;
          hold_timer = 1'b1;
        end
      end
      ST_TRIP: begin
        if (timer_q == COOL_LAST) begin
          if (retry_q >= RETRY_MAX) state_d = ST_LOCKOUT;
          else if (enable_req)      state_d = ST_SOFTSTART;
          else                      state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timer restarts on every state change and only runs in the timed states.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (hold_timer || state_q == ST_IDLE || state_q == ST_LOCKOUT) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    power_en_d = (state_d == ST_SOFTSTART) || (state_d == ST_RUN);
    fault_d    = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      power_en_q   <= 1'b0;
      trip_pulse_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      power_en_q   <= power_en_d;
      trip_pulse_q <= trip_pulse_d;
      fault_q      <= fault_d;
    end
  end

  assign power_en   = power_en_q;
  assign trip_pulse = trip_pulse_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule

// File: tb/tb_overcurrent_retry_ctrl.sv
// Bench for overcurrent_retry_ctrl: fixed vector table, hand-written corner sequences,
// then randomized stimulus against a countdown-based behavioural model.
module tb_overcurrent_retry_ctrl;

  localparam int B = 4;
  localparam int C = 8;
  localparam int M = 2;
  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_req = 1'b0;
  logic       current_high = 1'b0;
  logic       fault_clr = 1'b0;
  logic       power_en;
  logic       trip_pulse;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit r, e, c, f;
    int st;
    bit pw, tp, ft;
    int rc;
  } vec_t;

  vec_t vq[$];

  // Behavioural model: each timed phase holds a countdown of remaining cycles.
  int m_st, m_left, m_run, m_rc;
  bit m_tp;

  overcurrent_retry_ctrl #(
    .BLANK_CYCLES   (B),
    .COOLDOWN_CYCLES(C),
    .MAX_RETRIES    (M),
    .STABLE_CYCLES  (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_req  (enable_req),
    .current_high(current_high),
    .fault_clr   (fault_clr),
    .power_en    (power_en),
    .trip_pulse  (trip_pulse),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit e, bit c, bit f, int st, bit pw, bit tp, bit ft, int rc);
    vec_t x;
    x.r = r; x.e = e; x.c = c; x.f = f;
    x.st = st; x.pw = pw; x.tp = tp; x.ft = ft; x.rc = rc;
    return x;
  endfunction

  task automatic add(input int n, input bit r, input bit e, input bit c, input bit f,
                     input int st, input bit pw, input bit tp, input bit ft, input int rc);
    for (int i = 0; i < n; i++) vq.push_back(mk(r, e, c, f, st, pw, tp, ft, rc));
  endtask

  task automatic check(input string tag, input string what, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s %s: got %0d expected %0d", tag, what, got, exp);
  endtask

  task automatic apply(input vec_t x, input string tag);
    rst = x.r; enable_req = x.e; current_high = x.c; fault_clr = x.f;
    @(posedge clk);
    #1;
    check(tag, "state",      int'(state),      x.st);
    check(tag, "power_en",   int'(power_en),   int'(x.pw));
    check(tag, "trip_pulse", int'(trip_pulse), int'(x.tp));
    check(tag, "fault",      int'(fault),      int'(x.ft));
    check(tag, "retry_cnt",  int'(retry_cnt),  x.rc);
  endtask

  task automatic cyc(input string tag, input bit r, input bit e, input bit c, input bit f,
                     input int st, input bit pw, input bit tp, input bit ft, input int rc);
    apply(mk(r, e, c, f, st, pw, tp, ft, rc), tag);
  endtask

  // From IDLE with a zero count: hold current_high until the second trip locks out.
  task automatic to_lockout(input string tag);
    for (int i = 0; i < 4; i++) cyc(tag, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    cyc(tag, 0, 1, 1, 0, 2, 1, 0, 0, 0);
    cyc(tag, 0, 1, 1, 0, 3, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) cyc(tag, 0, 1, 1, 0, 3, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(tag, 0, 1, 1, 0, 1, 1, 0, 0, 1);
    cyc(tag, 0, 1, 1, 0, 2, 1, 0, 0, 1);
    cyc(tag, 0, 1, 1, 0, 3, 0, 1, 0, 2);
    for (int i = 0; i < 7; i++) cyc(tag, 0, 1, 1, 0, 3, 0, 0, 0, 2);
    cyc(tag, 0, 1, 1, 0, 4, 0, 0, 1, 2);
  endtask

  task automatic model_step(input bit r, input bit e, input bit c, input bit f);
    m_tp = 1'b0;
    if (r) begin
      m_st = 0; m_rc = 0; m_left = 0; m_run = 0;
    end else begin
      case (m_st)
        0: if (e) begin m_st = 1; m_left = B; end
        1: begin
          if (!e) m_st = 0;
          else begin
            m_left--;
            if (m_left == 0) begin m_st = 2; m_run = 0; end
          end
        end
        2: begin
          if (c) begin
            m_st = 3; m_left = C; m_tp = 1'b1;
            if (m_rc < M) m_rc++;
          end else if (!e) begin
            m_st = 0; m_rc = 0;
          end else begin
            m_run++;
            if (m_run >= S) m_rc = 0;
          end
        end
        3: begin
          m_left--;
          if (m_left == 0) begin
            if (m_rc >= M) m_st = 4;
            else if (e) begin m_st = 1; m_left = B; end
            else m_st = 0;
          end
        end
        4: if (f) begin m_st = 0; m_rc = 0; end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic rand_step(input bit r, input bit e, input bit c, input bit f, input string tag);
    model_step(r, e, c, f);
    apply(mk(r, e, c, f, m_st, (m_st == 1 || m_st == 2), m_tp, (m_st == 4), m_rc), tag);
  endtask

  initial begin
    bit en_r;

    // --- vector table: enable/disable, blanking, first trip, stability clear ---
    add(1,  1, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(4,  0, 1, 0, 0,  1, 1, 0, 0, 0);
    add(1,  0, 1, 0, 1,  2, 1, 0, 0, 0);
    add(1,  0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(2,  0, 1, 1, 0,  1, 1, 0, 0, 0);
    add(2,  0, 1, 0, 0,  1, 1, 0, 0, 0);
    add(1,  0, 1, 0, 0,  2, 1, 0, 0, 0);
    add(1,  0, 1, 1, 0,  3, 0, 1, 0, 1);
    add(2,  0, 1, 0, 0,  3, 0, 0, 0, 1);
    add(2,  0, 0, 1, 0,  3, 0, 0, 0, 1);
    add(3,  0, 1, 0, 0,  3, 0, 0, 0, 1);
    add(4,  0, 1, 0, 0,  1, 1, 0, 0, 1);
    add(1,  0, 1, 0, 0,  2, 1, 0, 0, 1);
    add(15, 0, 1, 0, 1,  2, 1, 0, 0, 1);
    add(1,  0, 1, 0, 0,  2, 1, 0, 0, 0);
    add(1,  0, 1, 1, 0,  3, 0, 1, 0, 1);
    add(7,  0, 0, 0, 0,  3, 0, 0, 0, 1);
    add(1,  0, 0, 0, 0,  0, 0, 0, 0, 1);
    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("tbl[%0d]", i));

    // --- lockout, enable ignored, fault_clr back to IDLE then SOFTSTART ---
    cyc("lock_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    to_lockout("lock_a");
    for (int i = 0; i < 6; i++) cyc("lock_hold", 0, (i % 2) == 1, 0, 0, 4, 0, 0, 1, 2);
    cyc("lock_clr", 0, 1, 0, 1, 0, 0, 0, 0, 0);
    cyc("lock_ss",  0, 1, 0, 0, 1, 1, 0, 0, 0);

    // --- reset while in LOCKOUT ---
    cyc("lock2_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    to_lockout("lock_b");
    cyc("rst_lock", 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // --- stability clear coinciding with a trip: increment from uncleared count ---
    for (int i = 0; i < 4; i++) cyc("coll", 0, 1, 0, 0, 1, 1, 0, 0, 0);
    cyc("coll", 0, 1, 0, 0, 2, 1, 0, 0, 0);
    cyc("coll", 0, 1, 1, 0, 3, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) cyc("coll", 0, 1, 0, 0, 3, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("coll", 0, 1, 0, 0, 1, 1, 0, 0, 1);
    cyc("coll", 0, 1, 0, 0, 2, 1, 0, 0, 1);
    for (int i = 0; i < 15; i++) cyc("coll_run", 0, 1, 0, 0, 2, 1, 0, 0, 1);
    cyc("coll_trip", 0, 1, 1, 0, 3, 0, 1, 0, 2);

    // --- trip and enable drop in the same cycle, cooldown ends in IDLE, reset in TRIP ---
    cyc("rst_trip0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("tdis", 0, 1, 0, 0, 1, 1, 0, 0, 0);
    cyc("tdis", 0, 1, 0, 0, 2, 1, 0, 0, 0);
    cyc("tdis_trip", 0, 0, 1, 0, 3, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) cyc("tdis_cool", 0, 0, 0, 0, 3, 0, 0, 0, 1);
    cyc("tdis_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("tdis2", 0, 1, 0, 0, 1, 1, 0, 0, 1);
    cyc("tdis2", 0, 1, 0, 0, 2, 1, 0, 0, 1);
    cyc("tdis2_trip", 0, 1, 1, 0, 3, 0, 1, 0, 2);
    cyc("tdis2_cool", 0, 1, 0, 0, 3, 0, 0, 0, 2);
    cyc("rst_trip", 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // --- randomized stimulus against the model ---
    en_r = 1'b0;
    rand_step(1, 0, 0, 0, "rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      bit r, c, f;
      r = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 19) == 0) en_r = !en_r;
      c = ($urandom_range(0, 11) == 0);
      f = ($urandom_range(0, 24) == 0);
      rand_step(r, en_r, c, f, $sformatf("rnd[%0d]", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/overcurrent_retry_ctrl.md
# overcurrent_retry_ctrl

Sequences the load power switch around the over-current detector: soft-starts the load with a blanking window, cuts power when the detector asserts `current_high`, waits a cooldown, and auto-retries a bounded number of times before latching a fault. Sits between the user enable logic and the power-stage gate driver, consuming the detector's `current_high` flag.

## Interface
Parameters:
- `BLANK_CYCLES`, 500: soft-start window after power-on during which `current_high` is ignored (inrush); must be ≥ 1.
- `COOLDOWN_CYCLES`, 50000: power-off time after a trip; must be ≥ 1.
- `MAX_RETRIES`, 3: trips tolerated before lockout; must be ≥ 1.
- `STABLE_CYCLES`, 100000: continuous RUN time after which the retry count is cleared; must be ≥ 1.

Ports:
- `clk`, input, 1: single clock, all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `enable_req`, input, 1: level request to power the load.
- `current_high`, input, 1: over-current flag from the detector.
- `fault_clr`, input, 1: clears lockout (level, sampled each cycle).
- `power_en`, output, 1: gate-driver enable, registered.
- `trip_pulse`, output, 1: one-cycle pulse on each trip.
- `fault`, output, 1: high while in LOCKOUT.
- `retry_cnt`, output, $clog2(MAX_RETRIES+1): trips since last clear.
- `state`, output, 3: IDLE=0, SOFTSTART=1, RUN=2, TRIP=3, LOCKOUT=4.

## Operation
- One shared timer, width $clog2(max parameter+1), cleared on every state entry.
- IDLE: `power_en`=0. If `enable_req` → SOFTSTART.
- SOFTSTART: `power_en`=1, `current_high` ignored. `enable_req`=0 → IDLE. Timer reaches BLANK_CYCLES-1 → RUN.
- RUN: `power_en`=1. Priority order each cycle: (1) `current_high`=1 → TRIP, `trip_pulse`=1, `retry_cnt` incremented (saturates at MAX_RETRIES); (2) `enable_req`=0 → IDLE, `retry_cnt` cleared; (3) timer reaches STABLE_CYCLES-1 → `retry_cnt` cleared, timer holds (saturates), stay in RUN.
- TRIP: `power_en`=0, `enable_req` and `current_high` ignored. Timer reaches COOLDOWN_CYCLES-1 → LOCKOUT if `retry_cnt` ≥ MAX_RETRIES, else SOFTSTART if `enable_req`=1, else IDLE (`retry_cnt` retained).
- LOCKOUT: `power_en`=0, `fault`=1; `enable_req` ignored. `fault_clr`=1 → IDLE, `retry_cnt` cleared. If `enable_req` is still high, IDLE then proceeds to SOFTSTART on the following cycle; there is no direct LOCKOUT→SOFTSTART path.
- `fault_clr` outside LOCKOUT: no effect.

## Timing
- Reset values: state IDLE, `power_en`=0, `trip_pulse`=0, `fault`=0, `retry_cnt`=0, timer=0. `rst` mid-operation forces these on the next edge, including from LOCKOUT.
- All outputs are registered from the next-state; they change on the same edge as the state.
- `enable_req` rises at edge N → SOFTSTART and `power_en`=1 after edge N.
- SOFTSTART lasts exactly BLANK_CYCLES cycles.
- `current_high` sampled 1 in RUN at edge N → `power_en`=0, `trip_pulse`=1, `retry_cnt`+1 after edge N. `trip_pulse` returns to 0 after edge N+1.
- TRIP lasts exactly COOLDOWN_CYCLES cycles with `power_en`=0.
- `current_high` and `enable_req` falling in the same RUN cycle → trip wins.
- Retry-count clear at STABLE_CYCLES and a trip in the same cycle → trip wins; count increments from the uncleared value.

## Test plan
Use BLANK_CYCLES=4, COOLDOWN_CYCLES=8, MAX_RETRIES=2, STABLE_CYCLES=16.
- Reset then `enable_req`=1 → `power_en` rises one cycle later, `state`=1 for 4 cycles then 2. Drop `enable_req` → `state`=0, `power_en`=0 next cycle.
- `current_high` pulsed during SOFTSTART → ignored, no `trip_pulse`. Pulsed in RUN → `power_en`=0 and single `trip_pulse` next cycle, `retry_cnt`=1, 8 cycles off, then SOFTSTART.
- `current_high` held high → two trips, then LOCKOUT with `fault`=1, `retry_cnt`=2, `power_en`=0. `enable_req` toggling has no effect. `fault_clr` → IDLE, count 0, then SOFTSTART with `enable_req` high.
- One trip, then 16 clean RUN cycles → `retry_cnt` returns to 0. A second trip then yields `retry_cnt`=1, not lockout.
- `current_high`=1 and `enable_req`=0 in the same RUN cycle → TRIP taken. At cooldown end with `enable_req`=0 → IDLE.
- Assert `rst` during TRIP and again during LOCKOUT → all outputs at reset values next cycle.
